// File: rtl/fast_command_encoder.sv
// Fast-command encoder: buffers 8-bit commands in a FIFO and serialises one word per 8 clocks, MSB first.
// Optional macro FC_BCR_GEN_EN inserts BCR_WORD once per orbit of ORBIT_WORDS word slots.
module fast_command_encoder #(
  parameter logic [7:0]  IDLE_WORD   = 8'hAC,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [7:0]  BCR_WORD    = 8'h5A,
  parameter int unsigned ORBIT_WORDS = 3564
) (
  input  logic                          fc_clk_i,
  input  logic                          fc_rst_i,
  input  logic [7:0]                    cmd_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  output logic                          fc_sig_o,
  output logic                          word_start_o,
  output logic                          cmd_sent_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [7:0]      shifter_q, shifter_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            fc_sig_q, fc_sig_d;
  logic            word_start_q, word_start_d;
  logic            cmd_sent_q, cmd_sent_d;
  logic            push, pop, boundary, fifo_empty, bcr_slot;

  // Ready depends only on the stored level, so a full FIFO never accepts even while popping.
  assign fifo_empty  = (level_q == '0);
  assign cmd_ready_o = (level_q != LvlW'(FIFO_DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;
  assign boundary    = (bit_cnt_q == 3'd7);
  assign pop         = boundary && !fifo_empty && !bcr_slot;

`ifdef FC_BCR_GEN_EN
  localparam int unsigned OrbW = $clog2(ORBIT_WORDS);

  logic [OrbW-1:0] orbit_cnt_q, orbit_cnt_d;

  // orbit_cnt_q is the slot index of the word currently held in the shifter.
  always_comb begin
    orbit_cnt_d = orbit_cnt_q;
    if (boundary) begin
      if (orbit_cnt_q == OrbW'(ORBIT_WORDS - 1)) begin
        orbit_cnt_d = '0;
      end else begin
        orbit_cnt_d = orbit_cnt_q + OrbW'(1);
      end
    end
  end

  assign bcr_slot = boundary && (orbit_cnt_d == OrbW'(ORBIT_WORDS - 1));

  always_ff @(posedge fc_clk_i or posedge fc_rst_i) begin
    if (fc_rst_i) begin
      orbit_cnt_q <= '0;
    end else begin
      orbit_cnt_q <= orbit_cnt_d;
    end
  end
`else
  assign bcr_slot = 1'b0;

  if (ORBIT_WORDS < 2) begin : g_orbit_unused
  end
`endif

  always_ff @(posedge fc_clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= cmd_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // The serialiser runs every edge; words are only swapped at the bit-7 boundary.
  always_comb begin
    fc_sig_d     = shifter_q[7];
    word_start_d = (bit_cnt_q == 3'd0);
    cmd_sent_d   = pop;
    if (boundary) begin
      bit_cnt_d = 3'd0;
      if (bcr_slot) begin
        shifter_d = BCR_WORD;
      end else if (pop) begin
        shifter_d = fifo_mem_q[rd_ptr_q];
      end else begin
        shifter_d = IDLE_WORD;
      end
    end else begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shifter_d = {shifter_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge fc_clk_i or posedge fc_rst_i) begin
    if (fc_rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      shifter_q    <= IDLE_WORD;
      bit_cnt_q    <= 3'd0;
      fc_sig_q     <= 1'b0;
      word_start_q <= 1'b0;
      cmd_sent_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      shifter_q    <= shifter_d;
      bit_cnt_q    <= bit_cnt_d;
      fc_sig_q     <= fc_sig_d;
      word_start_q <= word_start_d;
      cmd_sent_q   <= cmd_sent_d;
    end
  end

  assign fc_sig_o     = fc_sig_q;
  assign word_start_o = word_start_q;
  assign cmd_sent_o   = cmd_sent_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_fast_command_encoder.sv
// Directed bench for fast_command_encoder: expected words and cmd_sent edges are queued
// as stimulus is driven and consumed as the serial stream is reassembled.
module tb_fast_command_encoder;

  localparam logic [7:0] IDLE = 8'hAC;

  logic       fc_clk_i = 1'b0;
  logic       fc_rst_i = 1'b1;
  logic [7:0] cmd_i = 8'h00;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic       fc_sig_o;
  logic       word_start_o;
  logic       cmd_sent_o;
  logic [2:0] fifo_level_o;

  int         nChecks = 0;
  int         nErrors = 0;
  int         edgeCnt = 0;
  logic [7:0] frameBits = 8'h00;
  logic [7:0] expWords[$];
  int         expSent[$];

  fast_command_encoder #(
    .IDLE_WORD  (8'hAC),
    .FIFO_DEPTH (4)
  ) dut (
    .fc_clk_i     (fc_clk_i),
    .fc_rst_i     (fc_rst_i),
    .cmd_i        (cmd_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .fc_sig_o     (fc_sig_o),
    .word_start_o (word_start_o),
    .cmd_sent_o   (cmd_sent_o),
    .fifo_level_o (fifo_level_o)
  );

  always #5 fc_clk_i = ~fc_clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s at edge %0d: observed %0h expected %0h", tag, edgeCnt, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    cmd_valid_i = valid;
    cmd_i       = data;
  endtask

  // One rising edge, then sample on the falling edge and feed the scoreboard.
  task automatic stepEdge();
    int  bitIdx;
    logic expSentNow;
    logic [7:0] expWord;
    @(posedge fc_clk_i);
    @(negedge fc_clk_i);
    edgeCnt++;
    bitIdx = (edgeCnt - 1) % 8;
    checkOutput("word_start", {31'd0, word_start_o}, {31'd0, bitIdx == 0});
    frameBits = {frameBits[6:0], fc_sig_o};
    if (bitIdx == 7) begin
      if (expWords.size() > 0) begin
        expWord = expWords.pop_front();
        checkOutput("frame_word", {24'd0, frameBits}, {24'd0, expWord});
      end else begin
        checkOutput("frame_unexpected", {24'd0, frameBits}, 32'hDEAD_BEEF);
      end
    end
    expSentNow = (expSent.size() > 0) && (expSent[0] == edgeCnt);
    if (expSentNow) begin
      void'(expSent.pop_front());
    end
    checkOutput("cmd_sent", {31'd0, cmd_sent_o}, {31'd0, expSentNow});
  endtask

  // Called on a falling edge; asserts reset, checks the immediate clear, releases after one rising edge.
  task automatic applyReset();
    fc_rst_i = 1'b1;
    #1;
    checkOutput("rst_fc_sig", {31'd0, fc_sig_o}, 32'd0);
    checkOutput("rst_word_start", {31'd0, word_start_o}, 32'd0);
    checkOutput("rst_cmd_sent", {31'd0, cmd_sent_o}, 32'd0);
    checkOutput("rst_level", {29'd0, fifo_level_o}, 32'd0);
    checkOutput("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    @(posedge fc_clk_i);
    @(negedge fc_clk_i);
    fc_rst_i  = 1'b0;
    edgeCnt   = 0;
    frameBits = 8'h00;
    expWords.delete();
    expSent.delete();
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00);
    @(negedge fc_clk_i);
    applyReset();

    $display("[TB] idle framing");
    repeat (8) expWords.push_back(IDLE);
    for (int i = 0; i < 64; i++) begin
      stepEdge();
      checkOutput("idle_level", {29'd0, fifo_level_o}, 32'd0);
    end

    $display("[TB] single command pushed just before a boundary");
    expWords.push_back(IDLE);
    expWords.push_back(8'h2D);
    expWords.push_back(IDLE);
    expSent.push_back(72);
    repeat (6) stepEdge();
    applyStimulus(1'b1, 8'h2D);
    stepEdge();
    checkOutput("single_level", {29'd0, fifo_level_o}, 32'd1);
    applyStimulus(1'b0, 8'h00);
    stepEdge();
    checkOutput("single_popped", {29'd0, fifo_level_o}, 32'd0);
    repeat (16) stepEdge();

    $display("[TB] back-to-back commands fill the FIFO");
    applyReset();
    expWords.push_back(IDLE);
    for (int w = 1; w <= 5; w++) begin
      expWords.push_back(8'(w));
      expSent.push_back(8 * w);
    end
    expWords.push_back(IDLE);
    for (int w = 1; w <= 4; w++) begin
      applyStimulus(1'b1, 8'(w));
      stepEdge();
    end
    checkOutput("full_ready", {31'd0, cmd_ready_o}, 32'd0);
    checkOutput("full_level", {29'd0, fifo_level_o}, 32'd4);
    applyStimulus(1'b1, 8'h05);
    repeat (3) begin
      stepEdge();
      checkOutput("full_hold_ready", {31'd0, cmd_ready_o}, 32'd0);
    end
    stepEdge();
    checkOutput("after_pop_ready", {31'd0, cmd_ready_o}, 32'd1);
    checkOutput("after_pop_level", {29'd0, fifo_level_o}, 32'd3);
    stepEdge();
    checkOutput("refill_level", {29'd0, fifo_level_o}, 32'd4);
    checkOutput("refill_ready", {31'd0, cmd_ready_o}, 32'd0);
    applyStimulus(1'b0, 8'h00);
    repeat (47) stepEdge();
    checkOutput("drained_level", {29'd0, fifo_level_o}, 32'd0);

    $display("[TB] reset in the middle of a command");
    applyReset();
    expWords.push_back(IDLE);
    expSent.push_back(8);
    applyStimulus(1'b1, 8'hF0);
    stepEdge();
    applyStimulus(1'b1, 8'hA1);
    stepEdge();
    applyStimulus(1'b1, 8'hB2);
    stepEdge();
    applyStimulus(1'b0, 8'h00);
    repeat (5) stepEdge();
    checkOutput("queued_level", {29'd0, fifo_level_o}, 32'd2);
    repeat (4) stepEdge();
    applyReset();
    repeat (4) expWords.push_back(IDLE);
    repeat (32) stepEdge();
    checkOutput("flushed_level", {29'd0, fifo_level_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/fast_command_encoder.md
Name: fast_command_encoder

Overview:
- Upstream neighbour of the fast-control LVDS driver stage. Runs on the fast-control bit clock.
- Accepts 8-bit fast-command words over a valid/ready handshake and buffers them in a small FIFO.
- Serialises one word per 8 clocks, MSB first, onto a single-bit stream. That stream is registered again by the driver stage and sent out differentially.
- Inserts a fixed IDLE word whenever no command is pending, so the link always carries a continuous 8-bit word framing.

Parameters:
IDLE_WORD, 8'hAC, word sent when FIFO is empty
FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16
BCR_WORD, 8'h5A, bunch-counter-reset word (used only with the optional feature)
ORBIT_WORDS, 3564, word slots per orbit (used only with the optional feature); must be >= 2

Ports:
fc_clk_i  in  1  fast-control bit clock; all logic is rising-edge on it
fc_rst_i  in  1  asynchronous, active-high reset
cmd_i  in  8  fast-command word
cmd_valid_i  in  1  cmd_i is valid
cmd_ready_o  out  1  FIFO can accept a word
fc_sig_o  out  1  serial fast-command bit stream, to fc_sig_i of the driver stage
word_start_o  out  1  high during the cycle in which fc_sig_o carries a word's MSB
cmd_sent_o  out  1  one-cycle pulse: a FIFO word was loaded into the shifter
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values (asynchronous, held while fc_rst_i = 1):
  - fc_sig_o = 0, word_start_o = 0, cmd_sent_o = 0.
  - FIFO empty, so fifo_level_o = 0 and cmd_ready_o = 1 (cmd_ready_o is combinational from FIFO state).
  - Internal: shifter = IDLE_WORD, bit_cnt = 0, orbit_cnt = 0.
- Handshake:
  - cmd_ready_o = (level != FIFO_DEPTH).
  - A push occurs on an edge where cmd_valid_i & cmd_ready_o.
  - When full, cmd_ready_o = 0 even if a pop happens in the same cycle; no bypass.
  - cmd_i is ignored when the push condition is false.
- Serialiser, evaluated every edge:
  - fc_sig_o <= shifter[7].
  - word_start_o <= (bit_cnt == 0).
  - If bit_cnt != 7: shifter <= shifter << 1 and bit_cnt <= bit_cnt + 1.
  - If bit_cnt == 7 (word boundary): bit_cnt <= 0 and shifter <= next word.
    - Next word = FIFO head, with a pop and cmd_sent_o <= 1, if the FIFO is non-empty.
    - Otherwise next word = IDLE_WORD.
  - cmd_sent_o is 0 on all other edges.
- Latency:
  - A word pushed at edge E is visible as FIFO head after E.
  - Its MSB appears on fc_sig_o one edge after the boundary load.
  - Minimum push-to-MSB latency is 2 edges: push at the edge where bit_cnt = 6, load at bit_cnt = 7, MSB out on the next edge.
  - Worst case is (level × 8) + 9 edges.
- Simultaneous push and pop: allowed when not full; level stays unchanged; FIFO order is preserved.
- Framing: after reset release the first word on fc_sig_o is IDLE_WORD. word_start_o first rises on the first edge after release.
- Reset mid-word: the partial word is abandoned. The FIFO is flushed and framing restarts from bit 0 of IDLE_WORD.
- FIFO pointers wrap modulo FIFO_DEPTH. Level is kept as a separate counter, range 0..FIFO_DEPTH.

Optional Feature:
- Macro FC_BCR_GEN_EN.
- Defined:
  - orbit_cnt counts word boundaries, 0..ORBIT_WORDS-1, and wraps to 0.
  - At the boundary where orbit_cnt == ORBIT_WORDS-1, the shifter loads BCR_WORD regardless of FIFO state. There is no pop, cmd_sent_o = 0, and a pending FIFO word waits one slot.
  - The first BCR slot after reset is the ORBIT_WORDS-th word.
- Undefined:
  - No orbit counter is built.
  - BCR_WORD and ORBIT_WORDS have no effect.
  - Behaviour is exactly as in Behaviour above.

Test Plan:
- Reset, then idle with cmd_valid_i = 0 for 64 edges:
  - fc_sig_o repeats 1,0,1,0,1,1,0,0 (IDLE_WORD 8'hAC).
  - word_start_o is high every 8th edge, starting at the first edge.
  - cmd_sent_o stays 0 and fifo_level_o stays 0.
- Push 8'h2D during the cycle before a boundary (bit_cnt = 6):
  - cmd_sent_o pulses at the boundary.
  - The next 8 bits are 0,0,1,0,1,1,0,1.
  - The following word is IDLE_WORD.
- Hold cmd_valid_i = 1 with words 01,02,03,04,05 back-to-back from reset:
  - The first four are accepted; cmd_ready_o falls with fifo_level_o = 4.
  - 05 is accepted only after the next pop.
  - Words are transmitted in order 01..05 with no IDLE in between.
- Assert fc_rst_i for one cycle midway through command 8'hF0 with 2 more words queued:
  - Outputs clear immediately and the FIFO empties.
  - After release the stream is IDLE only; the queued words are never sent.
- With FC_BCR_GEN_EN and ORBIT_WORDS = 4, push 8'h11 just before word slot 3:
  - Slot 3 carries 8'h5A; slot 4 carries 8'h11.
  - cmd_sent_o fires at the slot-4 boundary only.
  - The next BCR lands in slot 7.
